// File: rtl/fifo_word_unpacker.sv
// Read-side consumer for the wide async FIFO: pops one word at a time and
// emits it LSB-first as OUT_W-bit beats on a valid/ready stream.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a non-empty FIFO; pop strobe issued from here
// ST_WAIT | FIFO read data arrives; capture it into the shift register
// ST_SEND | presenting beats; last accepted beat returns to ST_IDLE
module fifo_word_unpacker #(
  parameter int DATA_W = 140,
  parameter int OUT_W  = 16
) (
  input  logic              clk_out,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] data_from_fifo,
  output logic              fifo_r_enable,
  output logic [OUT_W-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic [15:0]       word_cnt,
  output logic              busy
);

  localparam int BEATS = (DATA_W + OUT_W - 1) / OUT_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS + 1) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [BW-1:0]     r_beat;
  logic [15:0]       r_word_cnt;
  logic              w_send;
  logic              w_last;
  logic              w_accept;

  assign w_send   = (r_state == ST_SEND);
  assign w_last   = w_send && (r_beat == LAST_BEAT);
  assign w_accept = w_send && dout_ready;

  always_ff @(posedge clk_out) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_beat     <= '0;
      r_word_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_WAIT: begin
          r_shift <= data_from_fifo;
          r_beat  <= '0;
        end
        ST_SEND: begin
          if (w_accept) begin
            // zero fill keeps the partial final beat zero-extended
            r_shift <= r_shift >> OUT_W;
            r_beat  <= r_beat + BW'(1);
            if (w_last) begin
              r_word_cnt <= r_word_cnt + 16'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    fifo_r_enable = 1'b0;
    case (r_state)
      ST_IDLE: begin
        fifo_r_enable = !fifo_empty && !rst;
        if (fifo_r_enable) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (w_accept && w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign dout       = w_send ? r_shift[OUT_W-1:0] : '0;
  assign dout_valid = w_send;
  assign dout_last  = w_last;
  assign word_cnt   = r_word_cnt;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Directed bench for fifo_word_unpacker: a small FIFO model feeds words and
// each scenario task checks pops, beats, stalls, resets and the word counter.
module tb_fifo_word_unpacker;

  logic         clk_out;
  logic         rst;
  logic         fifo_empty;
  logic [139:0] data_from_fifo;
  logic         fifo_r_enable;
  logic [15:0]  dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;
  logic [15:0]  word_cnt;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [139:0] W_A = 140'hABC_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [139:0] W_B = 140'h5A5_1111_2222_3333_4444_5555_6666_7777_8888;

  logic [15:0] exp_a [0:8];
  logic [15:0] exp_b [0:8];

  fifo_word_unpacker dut (
    .clk_out       (clk_out),
    .rst           (rst),
    .fifo_empty    (fifo_empty),
    .data_from_fifo(data_from_fifo),
    .fifo_r_enable (fifo_r_enable),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dout_last     (dout_last),
    .word_cnt      (word_cnt),
    .busy          (busy)
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  // FIFO model: read data appears the cycle after a pop
  logic [139:0] fmem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk_out) begin
    if (fifo_r_enable) begin
      data_from_fifo <= fmem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [139:0] w);
    fmem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick();
    @(negedge clk_out);
    #1;
  endtask

  function automatic logic [15:0] exp_beat(input logic [139:0] w, input int k);
    logic [139:0] t;
    t = w >> (16 * k);
    return t[15:0];
  endfunction

  task automatic wait_pop(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fifo_r_enable === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dout_ready = 1'b1;
    push(W_A);
    repeat (5) begin
      tick();
      checks++;
      if (fifo_r_enable !== 1'b0) begin
        errors++; $display("FAIL reset_pop got %b exp 0", fifo_r_enable);
      end
      checks++;
      if ({dout_valid, dout_last, busy, dout} !== 19'd0) begin
        errors++; $display("FAIL reset_outs got v%b l%b b%b d%h exp 0", dout_valid, dout_last, busy, dout);
      end
      checks++;
      if (word_cnt !== 16'h0000) begin
        errors++; $display("FAIL reset_cnt got %h exp 0000", word_cnt);
      end
    end
  endtask

  task automatic test_single_word();
    rst = 1'b0;
    #1;
    checks++;
    if (fifo_r_enable !== 1'b1) begin
      errors++; $display("FAIL single_pop got %b exp 1", fifo_r_enable);
    end
    tick();
    checks++;
    if ({fifo_r_enable, dout_valid, busy} !== 3'b001) begin
      errors++; $display("FAIL single_wait got pop%b v%b b%b exp pop0 v0 b1", fifo_r_enable, dout_valid, busy);
    end
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++;
      if (dout_valid !== 1'b1 || dout !== exp_a[k]) begin
        errors++; $display("FAIL single_beat%0d got v%b %h exp v1 %h", k, dout_valid, dout, exp_a[k]);
      end
      checks++;
      if (dout_last !== (k == 8)) begin
        errors++; $display("FAIL single_last%0d got %b exp %b", k, dout_last, (k == 8));
      end
    end
    tick();
    checks++;
    if (word_cnt !== 16'd1 || busy !== 1'b0 || dout_valid !== 1'b0) begin
      errors++; $display("FAIL single_done got cnt %h b%b v%b exp cnt 0001 b0 v0", word_cnt, busy, dout_valid);
    end
    repeat (3) begin
      checks++;
      if (fifo_r_enable !== 1'b0) begin
        errors++; $display("FAIL single_no_pop got %b exp 0", fifo_r_enable);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    push(W_B);
    #1;
    wait_pop(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bp_pop got no pop exp pop");
    end
    tick();
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++;
      if (dout_valid !== 1'b1 || dout !== exp_b[k] || dout_last !== (k == 8)) begin
        errors++; $display("FAIL bp_beat%0d got v%b l%b %h exp v1 l%b %h", k, dout_valid, dout_last, dout, (k == 8), exp_b[k]);
      end
      if (k == 3) begin
        dout_ready = 1'b0;
        repeat (3) begin
          tick();
          checks++;
          if (dout_valid !== 1'b1 || dout !== exp_b[3] || dout_last !== 1'b0) begin
            errors++; $display("FAIL bp_stall got v%b l%b %h exp v1 l0 %h", dout_valid, dout_last, dout, exp_b[3]);
          end
        end
        dout_ready = 1'b1;
      end
    end
    tick();
    checks++;
    if (word_cnt !== 16'd2 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_done got cnt %h b%b exp cnt 0002 b0", word_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [139:0] bw [0:3];
    int pop_off [0:3];
    int pops;
    int beats;
    pops = 0;
    beats = 0;
    for (int i = 0; i < 4; i++) begin
      bw[i] = '0;
      for (int k = 0; k < 8; k++) begin
        bw[i][k*16 +: 16] = {4'hC, 4'(i), 4'(k), 4'h5};
      end
      bw[i][139:128] = {4'(i), 8'hEE};
      pop_off[i] = -1;
      push(bw[i]);
    end
    #1;
    for (int c = 0; c < 60; c++) begin
      if (fifo_r_enable === 1'b1) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL b2b_pop_busy cycle %0d got busy %b exp 0", c, busy);
        end
        if (pops < 4) pop_off[pops] = c;
        pops++;
      end
      if (dout_valid === 1'b1) begin
        checks++;
        if (beats >= 36) begin
          errors++; $display("FAIL b2b_extra_beat got beat %0d exp at most 36", beats + 1);
        end else if (dout !== exp_beat(bw[beats / 9], beats % 9) || dout_last !== ((beats % 9) == 8)) begin
          errors++; $display("FAIL b2b_beat%0d got %h l%b exp %h l%b", beats, dout,
                             dout_last, exp_beat(bw[beats / 9], beats % 9), ((beats % 9) == 8));
        end
        beats++;
      end
      tick();
    end
    checks++;
    if (pops !== 4 || beats !== 36) begin
      errors++; $display("FAIL b2b_counts got pops %0d beats %0d exp 4 36", pops, beats);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (pop_off[i] - pop_off[0] !== 11 * i) begin
        errors++; $display("FAIL b2b_pop_offset%0d got %0d exp %0d", i, pop_off[i] - pop_off[0], 11 * i);
      end
    end
    checks++;
    if (word_cnt !== 16'd6) begin
      errors++; $display("FAIL b2b_cnt got %h exp 0006", word_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    push(W_A);
    #1;
    wait_pop(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL mid_pop got no pop exp pop");
    end
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (dout !== exp_a[k]) begin
        errors++; $display("FAIL mid_beat%0d got %h exp %h", k, dout, exp_a[k]);
      end
    end
    rst = 1'b1;
    push(W_B);
    #1;
    checks++;
    if (fifo_r_enable !== 1'b0) begin
      errors++; $display("FAIL mid_rst_pop got %b exp 0", fifo_r_enable);
    end
    tick();
    checks++;
    if ({dout_valid, dout_last, busy, dout, fifo_r_enable} !== 20'd0 || word_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_rst_outs got v%b l%b b%b d%h pop%b cnt %h exp all 0",
                         dout_valid, dout_last, busy, dout, fifo_r_enable, word_cnt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (fifo_r_enable !== 1'b1) begin
      errors++; $display("FAIL mid_next_pop got %b exp 1", fifo_r_enable);
    end
    tick();
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++;
      if (dout_valid !== 1'b1 || dout !== exp_b[k] || dout_last !== (k == 8)) begin
        errors++; $display("FAIL mid_b_beat%0d got v%b l%b %h exp v1 l%b %h", k, dout_valid, dout_last, dout, (k == 8), exp_b[k]);
      end
    end
    tick();
    checks++;
    if (word_cnt !== 16'd1 || fifo_r_enable !== 1'b0) begin
      errors++; $display("FAIL mid_cnt got cnt %h pop%b exp cnt 0001 pop0", word_cnt, fifo_r_enable);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    force dut.r_word_cnt = 16'hFFFF;
    tick();
    release dut.r_word_cnt;
    tick();
    checks++;
    if (word_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload got %h exp ffff", word_cnt);
    end
    push(W_B);
    #1;
    wait_pop(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL wrap_pop got no pop exp pop");
    end
    repeat (10) tick();
    checks++;
    if (word_cnt !== 16'hFFFF || dout_last !== 1'b1) begin
      errors++; $display("FAIL wrap_pre_last got cnt %h l%b exp ffff l1", word_cnt, dout_last);
    end
    tick();
    checks++;
    if (word_cnt !== 16'h0000 || busy !== 1'b0) begin
      errors++; $display("FAIL wrap_cnt got cnt %h b%b exp 0000 b0", word_cnt, busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    exp_a = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123, 16'h0ABC};
    exp_b = '{16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h05A5};
    rst = 1'b1;
    dout_ready = 1'b1;
    test_reset();
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
